// File: rtl/bus_arbiter4_pkg.sv
// Shared types and constants for the 4-way round-robin bus arbiter.
// Includes the round-robin winner search used by the arbitration FSM.
package bus_arbiter4_pkg;

  localparam int NUM_REQ       = 4;
  localparam int MAX_HOLD_DFLT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Nearest requester after ptr wins; ptr itself is searched last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/MUX4T1_32.sv
// 4:1 multiplexer for 32-bit data; purely combinational.
// No latency, no flow control.
module MUX4T1_32 (
  input  logic [1:0]  s,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] d3,
  output logic [31:0] y
);

  always_comb begin
    case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-requester round-robin bus arbiter with hold limit and forced-release pulse.
// Grant one cycle after sampled req; owner keeps bus until done, req drop or MAX_HOLD cycles.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic [31:0] din3,
  input  logic        done,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic        valid,
  output logic [31:0] dout,
  output logic        timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  hold_q, hold_d;
  logic [1:0]  ptr_q, ptr_d;

  logic [1:0]  win;
  logic        expire;
  logic        rel_now;
  logic [31:0] mux_y;

  assign win     = rr_pick(req, ptr_q);
  assign expire  = (hold_q == HOLD_LAST);
  assign rel_now = done | ~req[sel_q] | expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= 8'd0;
      ptr_q     <= 2'b11;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: begin
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        if (|req) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          ptr_d   = win;
          valid_d = 1'b1;
          hold_d  = 8'd0;
        end
      end
      BUSY: begin
        if (rel_now) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          valid_d   = 1'b0;
          // Only a pure expiry with the owner still asking counts as forced.
          timeout_d = expire & ~done & req[sel_q];
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  MUX4T1_32 u_dout_mux (
    .s  (sel_q),
    .d0 (din0),
    .d1 (din1),
    .d2 (din2),
    .d3 (din3),
    .y  (mux_y)
  );

  assign dout    = valid_q ? mux_y : 32'h0;
  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_valid_gnt  : assert property (@(posedge clk) disable iff (!rst_n) valid_q == (gnt_q != 4'b0000));
  a_hold_range : assert property (@(posedge clk) disable iff (!rst_n) hold_q <= HOLD_LAST);

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: directed tables, corner sequences and random traffic vs a reference model.
module tb_bus_arbiter4;

  localparam int MAX_HOLD = 16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din0, din1, din2, din3;
  logic        done;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        valid;
  logic [31:0] dout;
  logic        timeout;

  int n_vec;
  int n_bad;

  // Reference model: owner index (-1 none), cycles granted so far, last winner.
  int m_owner;
  int m_len;
  int m_last;
  int m_sel;
  bit m_to;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_gnt;
    logic       exp_to;
  } vec_t;

  vec_t rr_tbl[9];

  bus_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .din0    (din0),
    .din1    (din1),
    .din2    (din2),
    .din3    (din3),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .dout    (dout),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] din_of(input int i);
    case (i)
      0:       return din0;
      1:       return din1;
      2:       return din2;
      default: return din3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_len   = 0;
    m_last  = 3;
    m_sel   = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    bit expire;
    bit found;
    int idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (!found && req[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_last  = idx;
          m_sel   = idx;
          m_len   = 1;
        end
      end
    end else begin
      expire = (m_len == MAX_HOLD);
      if (done || !req[m_owner] || expire) begin
        m_to    = expire && !done && req[m_owner];
        m_owner = -1;
      end else begin
        m_len++;
        m_to = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0]  eg;
    logic [31:0] ed;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    ed = (m_owner >= 0) ? din_of(m_owner) : 32'h0;
    chk({tag, ".gnt"},     32'(gnt),     32'(eg));
    chk({tag, ".sel"},     32'(sel),     32'(m_sel));
    chk({tag, ".valid"},   32'(valid),   32'(m_owner >= 0));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    chk({tag, ".dout"},    dout,         ed);
  endtask

  // Inputs are stable here (set at edge+1), so the model sees what the DUT samples.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    #1;
    check_model("rst");
    tick("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    din0  = 32'h1111_0000;
    din1  = 32'h2222_0001;
    din2  = 32'h3333_0002;
    din3  = 32'h4444_0003;
    model_reset();

    rr_tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0};
    rr_tbl[1] = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    rr_tbl[2] = '{4'b1111, 1'b1, 4'b0010, 1'b0};
    rr_tbl[3] = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    rr_tbl[4] = '{4'b1111, 1'b1, 4'b0100, 1'b0};
    rr_tbl[5] = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    rr_tbl[6] = '{4'b1111, 1'b1, 4'b1000, 1'b0};
    rr_tbl[7] = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    rr_tbl[8] = '{4'b1111, 1'b1, 4'b0001, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_model("por");
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick("idle");
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_dout", dout, 32'h0);
      chk("idle_to", 32'(timeout), 32'h0);
    end

    // Round-robin rotation with done on every busy cycle
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      req  = rr_tbl[i].req;
      done = rr_tbl[i].done;
      tick("rr");
      chk("rr_gnt", 32'(gnt), 32'(rr_tbl[i].exp_gnt));
      chk("rr_to", 32'(timeout), 32'(rr_tbl[i].exp_to));
    end

    // Hold expiry with forced release
    reset_dut();
    din2 = 32'hDEADBEEF;
    req  = 4'b0100;
    for (int i = 1; i <= MAX_HOLD; i++) begin
      tick("hold");
      chk("hold_gnt", 32'(gnt), 32'h4);
      chk("hold_dout", dout, 32'hDEADBEEF);
    end
    tick("hold_rel");
    chk("expire_gnt", 32'(gnt), 32'h0);
    chk("expire_to", 32'(timeout), 32'h1);
    chk("expire_dout", dout, 32'h0);
    tick("regrant");
    chk("regrant_gnt", 32'(gnt), 32'h4);
    chk("regrant_to", 32'(timeout), 32'h0);

    // done coinciding with expiry: no timeout
    reset_dut();
    req = 4'b0010;
    for (int i = 1; i <= MAX_HOLD; i++) begin
      tick("done16");
      chk("done16_gnt", 32'(gnt), 32'h2);
      if (i == MAX_HOLD) done = 1'b1;
    end
    tick("done16_rel");
    done = 1'b0;
    chk("done16_rel_gnt", 32'(gnt), 32'h0);
    chk("done16_to", 32'(timeout), 32'h0);

    // Owner drops its request on its third busy cycle
    reset_dut();
    req = 4'b1001;
    for (int i = 1; i <= 3; i++) begin
      tick("drop");
      chk("drop_gnt", 32'(gnt), 32'h1);
    end
    req = 4'b1000;
    tick("drop_rel");
    chk("drop_rel_gnt", 32'(gnt), 32'h0);
    chk("drop_rel_to", 32'(timeout), 32'h0);
    tick("drop_next");
    chk("drop_next_gnt", 32'(gnt), 32'h8);

    // Asynchronous reset in the middle of a grant
    reset_dut();
    req = 4'b0100;
    tick("mid");
    tick("mid");
    chk("mid_gnt", 32'(gnt), 32'h4);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_to", 32'(timeout), 32'h0);
    check_model("arst");
    #1;
    req   = 4'b1111;
    rst_n = 1'b1;
    tick("post_rst");
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    // Random traffic; request pattern changes rarely so long holds occur
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) req = 4'($urandom);
      done = ($urandom_range(0, 11) == 0);
      din0 = $urandom;
      din1 = $urandom;
      din2 = $urandom;
      din3 = $urandom;
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive cycles one requester may hold a grant (legal range 2..255).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request per requester; level-sensitive, held high while the bus is wanted.
REQ-005 Port: din0..din3  input  32 each  data/address bus of requester 0..3.
REQ-006 Port: done  input  1  slave completion strobe for the current owner; ignored when not BUSY.
REQ-007 Port: gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-008 Port: sel  output  2  index of current or last owner, registered.
REQ-009 Port: valid  output  1  bus owned this cycle, registered; equals (gnt != 0).
REQ-010 Port: dout  output  32  din[sel] when valid, else 32'h0; combinational from registered sel/valid.
REQ-011 Port: timeout  output  1  one-cycle registered pulse when a grant is forcibly revoked.

Function
REQ-012 FSM SHALL have two states: IDLE (no owner) and BUSY (one owner).
REQ-013 In IDLE with req != 0, the next edge SHALL move to BUSY, set gnt one-hot for the winner, set sel to the winner index, clear hold_cnt; grant latency 1 cycle from sampled req.
REQ-014 Winner SHALL be chosen round-robin: search order ptr+1, ptr+2, ptr+3, ptr (mod 4); ptr is the 2-bit index of the last granted requester.
REQ-015 ptr SHALL update to the winner index on the edge the grant is issued.
REQ-016 In IDLE with req == 0, outputs SHALL hold gnt=0, valid=0; sel keeps its last value.
REQ-017 In BUSY, hold_cnt SHALL increment by 1 each cycle, 8-bit, no wrap reachable.
REQ-018 In BUSY, the next edge SHALL return to IDLE with gnt=0 if any of: done=1; req[sel]=0; hold_cnt == MAX_HOLD-1.
REQ-019 Consequently a grant lasts at most MAX_HOLD cycles and at least 1 cycle; at least one cycle with gnt=0 SHALL separate any two grants.
REQ-020 timeout SHALL pulse high for the one cycle after release only when the release was caused by hold_cnt expiry with done=0 and req[sel]=1.
REQ-021 done and expiry in the same cycle: normal release, no timeout pulse.
REQ-022 req changes during BUSY for non-owners SHALL have no effect until the next IDLE arbitration.
REQ-023 dout SHALL select via sel with no added latency; dout=0 whenever valid=0.

Reset
REQ-024 rst_n low SHALL asynchronously force: state=IDLE, gnt=4'b0000, sel=2'b00, valid=0, timeout=0, hold_cnt=0, ptr=2'b11 (requester 0 has first priority).
REQ-025 Reset asserted mid-BUSY SHALL drop gnt within the same cycle, without a timeout pulse.
REQ-026 After rst_n deasserts, first arbitration occurs on the first rising edge with req != 0.

Structure
REQ-027 Shared package/header SHALL hold: state encodings IDLE/BUSY, NUM_REQ=4, default MAX_HOLD=16.
REQ-028 The dout path SHALL instantiate the team's existing MUX4T1_32 with s=sel, output gated by valid; no other sub-module.

Verification
REQ-029 Reset, req=4'b0000 for 10 cycles -> gnt=0000, valid=0, dout=32'h0, timeout=0 throughout.
REQ-030 req=4'b1111 held, done=1 on every BUSY cycle -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-031 req=4'b0100 held, din2=32'hDEADBEEF, done=0 -> gnt=0100 and dout=32'hDEADBEEF for exactly 16 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=0100 again.
REQ-032 req=4'b0010, done=1 on the 16th BUSY cycle -> release, timeout stays 0.
REQ-033 Owner 0 drops req[0] on its 3rd BUSY cycle while req=4'b1000 -> gnt=0 next cycle, then gnt=1000.
REQ-034 rst_n pulsed low mid-BUSY with gnt=0100 -> gnt=0 immediately; after release with req=4'b1111 -> first gnt=0001.
